// File: rtl/gat_pkg.sv
// Shared constants and types for the new-feature BRAM path.
// Default geometry is 2708 nodes x 16 output features per layer.
package gat_pkg;

  localparam int NEW_FEATURE_WIDTH  = 32;
  localparam int NUM_SUBGRAPHS      = 2708;
  localparam int NUM_FEATURE_OUT    = 16;
  localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);

  typedef logic [NEW_FEATURE_WIDTH-1:0]  feat_word_t;
  typedef logic [NEW_FEATURE_ADDR_W-1:0] feat_addr_t;

  // One stage of the read-return tracker: a read was granted, and whether it was out of range.
  typedef struct packed {
    logic vld;
    logic oob;
  } rd_tag_t;

endpackage

// File: rtl/feat_bram_arbiter_rd_vld_delay.sv
// Delays the {vld, oob} tag of each granted read by LATENCY cycles to line it up with BRAM dout.
module rd_vld_delay
  import gat_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [LATENCY];

  // Clearing on reset drops any read still in flight, so it never produces a valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/feat_bram_arbiter.sv
// Single-port feature BRAM arbiter: write-priority with bounded read starvation, one access per cycle.
// Optional stall counters are built when FEAT_ARB_STATS_EN is defined.
module feat_bram_arbiter
  import gat_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH = gat_pkg::NEW_FEATURE_WIDTH,
  parameter int NUM_SUBGRAPHS     = gat_pkg::NUM_SUBGRAPHS,
  parameter int NUM_FEATURE_OUT   = gat_pkg::NUM_FEATURE_OUT,
  parameter int BRAM_RD_LATENCY   = 2,
  parameter int MAX_WR_BURST      = 8,
  localparam int DEPTH            = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  localparam int ADDR_W           = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_req,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [NEW_FEATURE_WIDTH-1:0] wr_din,
  output logic                         wr_gnt,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_gnt,
  output logic [NEW_FEATURE_WIDTH-1:0] rd_dout,
  output logic                         rd_dout_vld,
  output logic                         bram_en,
  output logic                         bram_we,
  output logic [ADDR_W-1:0]            bram_addr,
  output logic [NEW_FEATURE_WIDTH-1:0] bram_din,
  input  logic [NEW_FEATURE_WIDTH-1:0] bram_dout,
  output logic [ADDR_W:0]              wr_cnt,
  output logic                         feat_done,
  output logic                         addr_err
`ifdef FEAT_ARB_STATS_EN
  ,
  output logic [31:0]                  wr_stall_cnt,
  output logic [31:0]                  rd_stall_cnt
`endif
);

  localparam int BURST_W = $clog2(MAX_WR_BURST + 1);
  localparam logic [ADDR_W:0]      DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [BURST_W-1:0]   BURST_MAX = BURST_W'(MAX_WR_BURST);

  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [ADDR_W:0]    wr_cnt_q, wr_cnt_d;
  logic               feat_done_q, feat_done_d;
  logic               addr_err_q, addr_err_d;
  logic               wr_inr, rd_inr, force_rd;
  rd_tag_t            tag_in, tag_out;

  // Addresses are widened by one bit so a depth that is an exact power of two still compares correctly.
  always_comb begin
    wr_inr   = {1'b0, wr_addr} < DEPTH_C;
    rd_inr   = {1'b0, rd_addr} < DEPTH_C;
    force_rd = rd_req && (burst_cnt_q == BURST_MAX);
    rd_gnt   = rd_req && (!wr_req || force_rd);
    wr_gnt   = wr_req && !rd_gnt;

    bram_en   = 1'b0;
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    if (wr_gnt) begin
      bram_en   = wr_inr;
      bram_we   = wr_inr;
      bram_addr = wr_addr;
      bram_din  = wr_din;
    end else if (rd_gnt) begin
      bram_en   = rd_inr;
      bram_addr = rd_addr;
    end
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!rd_req || rd_gnt) begin
      burst_cnt_d = '0;
    end else if (wr_gnt && (burst_cnt_q != BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end

    wr_cnt_d = wr_cnt_q;
    if (wr_gnt && wr_inr && (wr_cnt_q != DEPTH_C)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    // Completion counts accepted writes only; rewriting an address still advances the count.
    feat_done_d = feat_done_q || (wr_cnt_q == DEPTH_C);
    addr_err_d  = addr_err_q || (wr_gnt && !wr_inr) || (rd_gnt && !rd_inr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
      wr_cnt_q    <= '0;
      feat_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      feat_done_q <= feat_done_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign tag_in.vld = rd_gnt;
  assign tag_in.oob = rd_gnt && !rd_inr;

  rd_vld_delay #(
    .LATENCY (BRAM_RD_LATENCY)
  ) u_rd_vld_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Out-of-range reads return zero; dout is also held at zero between valid returns.
  assign rd_dout     = (tag_out.vld && !tag_out.oob) ? bram_dout : '0;
  assign rd_dout_vld = tag_out.vld;
  assign wr_cnt      = wr_cnt_q;
  assign feat_done   = feat_done_q;
  assign addr_err    = addr_err_q;

`ifdef FEAT_ARB_STATS_EN
  logic [31:0] wr_stall_q, rd_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_stall_q <= '0;
      rd_stall_q <= '0;
    end else begin
      if (wr_req && !wr_gnt && (wr_stall_q != '1)) begin
        wr_stall_q <= wr_stall_q + 1'b1;
      end
      if (rd_req && !rd_gnt && (rd_stall_q != '1)) begin
        rd_stall_q <= rd_stall_q + 1'b1;
      end
    end
  end

  assign wr_stall_cnt = wr_stall_q;
  assign rd_stall_cnt = rd_stall_q;
`endif

endmodule

// File: tb/tb_feat_bram_arbiter.sv
// Randomized self-checking bench for feat_bram_arbiter with a behavioural BRAM and reference model.
// Stall-counter checks are compiled in when FEAT_ARB_STATS_EN is defined.
module tb_feat_bram_arbiter;

  localparam int W     = 32;
  localparam int LAT   = 2;
  localparam int MAXB  = 8;
  localparam int DEPTH = 43328;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_din;
  logic          wr_gnt, rd_gnt;
  logic [W-1:0]  rd_dout;
  logic          rd_dout_vld;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [W-1:0]  bram_din, bram_dout;
  logic [AW:0]   wr_cnt;
  logic          feat_done, addr_err;
`ifdef FEAT_ARB_STATS_EN
  logic [31:0]   wr_stall_cnt, rd_stall_cnt;
`endif

  always #5 clk = ~clk;

  feat_bram_arbiter #(
    .NEW_FEATURE_WIDTH (W),
    .NUM_SUBGRAPHS     (2708),
    .NUM_FEATURE_OUT   (16),
    .BRAM_RD_LATENCY   (LAT),
    .MAX_WR_BURST      (MAXB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_din       (wr_din),
    .wr_gnt       (wr_gnt),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_dout      (rd_dout),
    .rd_dout_vld  (rd_dout_vld),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din),
    .bram_dout    (bram_dout),
    .wr_cnt       (wr_cnt),
    .feat_done    (feat_done),
    .addr_err     (addr_err)
`ifdef FEAT_ARB_STATS_EN
    ,
    .wr_stall_cnt (wr_stall_cnt),
    .rd_stall_cnt (rd_stall_cnt)
`endif
  );

  // Behavioural single-port BRAM with LAT cycles from enable to dout.
  logic [W-1:0] mem   [DEPTH];
  logic [W-1:0] dpipe [LAT];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int i = 0; i < LAT; i++) dpipe[i] = '0;
  end

  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] <= bram_din;
    if (bram_en && !bram_we) dpipe[0] <= mem[bram_addr];
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end

  assign bram_dout = dpipe[LAT-1];

  // Reference model state.
  typedef struct {
    int           due;
    logic [W-1:0] data;
  } exp_t;

  exp_t         expQ [$];
  logic [W-1:0] sh [DEPTH];
  int           cyc;
  int           waitWrites;
  int           mWrCnt;
  bit           mDone;
  bit           mAddrErr;
  int           nVec;
  int           nMis;

  function automatic bit exp_rd_gnt();
    return rd_req && (!wr_req || (waitWrites == MAXB));
  endfunction

  function automatic bit exp_wr_gnt();
    return wr_req && !exp_rd_gnt();
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return AW'(DEPTH + $urandom_range(0, 20000));
    return AW'($urandom_range(0, 63));
  endfunction

  // Advance the model by one accepted cycle, then step the clock.
  task automatic tick();
    bit   eRd, eWr, nextDone;
    exp_t rec;
    eRd = exp_rd_gnt();
    eWr = exp_wr_gnt();
    nextDone = mDone || (mWrCnt == DEPTH);
    if (eWr) begin
      if (int'(wr_addr) < DEPTH) begin
        sh[wr_addr] = wr_din;
        if (mWrCnt < DEPTH) mWrCnt++;
      end else begin
        mAddrErr = 1'b1;
      end
    end
    if (eRd) begin
      rec.due = cyc + LAT;
      if (int'(rd_addr) < DEPTH) begin
        rec.data = sh[rd_addr];
      end else begin
        rec.data = '0;
        mAddrErr = 1'b1;
      end
      expQ.push_back(rec);
    end
    if (!rd_req || eRd) waitWrites = 0;
    else if (eWr && waitWrites < MAXB) waitWrites++;
    mDone = nextDone;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic pop_exp(output bit v, output logic [W-1:0] d);
    v = 1'b0;
    d = '0;
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      v = 1'b1;
      d = expQ[0].data;
      void'(expQ.pop_front());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_din = '0;
    expQ.delete();
    waitWrites = 0; mWrCnt = 0; mDone = 1'b0; mAddrErr = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    nVec++; if (rd_dout_vld !== 1'b0) begin nMis++; $display("FAIL reset_vld: got %b want 0", rd_dout_vld); end
    nVec++; if (rd_dout !== '0) begin nMis++; $display("FAIL reset_dout: got %h want 0", rd_dout); end
    nVec++; if (wr_cnt !== '0) begin nMis++; $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt); end
    nVec++; if (feat_done !== 1'b0) begin nMis++; $display("FAIL reset_done: got %b want 0", feat_done); end
    nVec++; if (addr_err !== 1'b0) begin nMis++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
    nVec++; if (bram_en !== 1'b0) begin nMis++; $display("FAIL reset_bram_en: got %b want 0", bram_en); end
    nVec++; if (bram_addr !== '0) begin nMis++; $display("FAIL reset_bram_addr: got %h want 0", bram_addr); end
    nVec++; if (wr_gnt !== 1'b0) begin nMis++; $display("FAIL reset_wr_gnt: got %b want 0", wr_gnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    bit           v, eW;
    logic [W-1:0] d;
    do_reset();
    wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = AW'(200); wr_din = $urandom;
    rd_addr = AW'(200 + $urandom_range(0, 15));
    for (int k = 0; k < 27; k++) begin
      #1;
      pop_exp(v, d);
      nVec++; if (rd_gnt !== ((k % 9) == 8)) begin nMis++; $display("FAIL cont_rd_gnt k=%0d: got %b want %b", k, rd_gnt, (k % 9) == 8); end
      nVec++; if (wr_gnt !== ((k % 9) != 8)) begin nMis++; $display("FAIL cont_wr_gnt k=%0d: got %b want %b", k, wr_gnt, (k % 9) != 8); end
      nVec++; if (rd_dout_vld !== v) begin nMis++; $display("FAIL cont_vld k=%0d: got %b want %b", k, rd_dout_vld, v); end
      if (v) begin
        nVec++; if (rd_dout !== d) begin nMis++; $display("FAIL cont_dout k=%0d: got %h want %h", k, rd_dout, d); end
      end
`ifdef FEAT_ARB_STATS_EN
      if (k == 8) begin
        nVec++; if (rd_stall_cnt !== 32'd8) begin nMis++; $display("FAIL stats_rd_stall: got %0d want 8", rd_stall_cnt); end
      end
      if (k == 9) begin
        nVec++; if (wr_stall_cnt !== 32'd1) begin nMis++; $display("FAIL stats_wr_stall: got %0d want 1", wr_stall_cnt); end
      end
`endif
      eW = exp_wr_gnt();
      tick();
      if (eW) begin
        wr_addr = wr_addr + 1'b1;
        wr_din  = $urandom;
      end else begin
        rd_addr = AW'(200 + $urandom_range(0, 15));
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      pop_exp(v, d);
      nVec++; if (rd_dout_vld !== v) begin nMis++; $display("FAIL cont_drain_vld j=%0d: got %b want %b", j, rd_dout_vld, v); end
      if (v) begin
        nVec++; if (rd_dout !== d) begin nMis++; $display("FAIL cont_drain_dout j=%0d: got %h want %h", j, rd_dout, d); end
      end
      tick();
    end
  endtask

  task automatic test_readback();
    bit           v;
    logic [W-1:0] d;
    wr_req = 1'b1; wr_addr = AW'(5); wr_din = 32'hDEADBEEF; rd_req = 1'b0;
    #1;
    nVec++; if (wr_gnt !== 1'b1) begin nMis++; $display("FAIL rb_wr_gnt: got %b want 1", wr_gnt); end
    nVec++; if ({bram_en, bram_we} !== 2'b11) begin nMis++; $display("FAIL rb_en_we: got %b want 11", {bram_en, bram_we}); end
    nVec++; if (bram_addr !== AW'(5)) begin nMis++; $display("FAIL rb_bram_addr: got %0d want 5", bram_addr); end
    nVec++; if (bram_din !== 32'hDEADBEEF) begin nMis++; $display("FAIL rb_bram_din: got %h want deadbeef", bram_din); end
    tick();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = AW'(5);
    #1;
    nVec++; if (rd_gnt !== 1'b1) begin nMis++; $display("FAIL rb_rd_gnt: got %b want 1", rd_gnt); end
    nVec++; if ({bram_en, bram_we} !== 2'b10) begin nMis++; $display("FAIL rb_rd_en_we: got %b want 10", {bram_en, bram_we}); end
    tick();
    rd_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      pop_exp(v, d);
      nVec++; if (rd_dout_vld !== (j == 1)) begin nMis++; $display("FAIL rb_vld j=%0d: got %b want %b", j, rd_dout_vld, j == 1); end
      if (j == 1) begin
        nVec++; if (rd_dout !== 32'hDEADBEEF) begin nMis++; $display("FAIL rb_dout: got %h want deadbeef", rd_dout); end
      end
      tick();
    end
  endtask

  task automatic test_oob();
    bit           v;
    logic [W-1:0] d;
    wr_req = 1'b1; wr_addr = AW'(DEPTH); wr_din = $urandom; rd_req = 1'b0;
    #1;
    nVec++; if (wr_gnt !== 1'b1) begin nMis++; $display("FAIL oob_wr_gnt: got %b want 1", wr_gnt); end
    nVec++; if (bram_en !== 1'b0) begin nMis++; $display("FAIL oob_wr_bram_en: got %b want 0", bram_en); end
    tick();
    wr_req = 1'b0;
    #1;
    nVec++; if (addr_err !== 1'b1) begin nMis++; $display("FAIL oob_addr_err: got %b want 1", addr_err); end
    nVec++; if (wr_cnt !== (AW+1)'(mWrCnt)) begin nMis++; $display("FAIL oob_wr_cnt: got %0d want %0d", wr_cnt, mWrCnt); end
    rd_req = 1'b1; rd_addr = AW'(50000);
    #1;
    nVec++; if (rd_gnt !== 1'b1) begin nMis++; $display("FAIL oob_rd_gnt: got %b want 1", rd_gnt); end
    nVec++; if (bram_en !== 1'b0) begin nMis++; $display("FAIL oob_rd_bram_en: got %b want 0", bram_en); end
    tick();
    rd_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      pop_exp(v, d);
      nVec++; if (rd_dout_vld !== (j == 1)) begin nMis++; $display("FAIL oob_vld j=%0d: got %b want %b", j, rd_dout_vld, j == 1); end
      if (j == 1) begin
        nVec++; if (rd_dout !== '0) begin nMis++; $display("FAIL oob_dout: got %h want 0", rd_dout); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit           v, eW, eR, wrPend, rdPend;
    logic [W-1:0] d;
    int           wrPct;
    wrPend = 1'b0; rdPend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      wrPct = (n < 1500) ? 85 : 50;
      if (!wrPend) begin
        wr_req  = ($urandom_range(0, 99) < wrPct);
        wr_addr = rand_addr();
        wr_din  = $urandom;
      end
      if (!rdPend) begin
        rd_req  = ($urandom_range(0, 99) < 45);
        rd_addr = rand_addr();
      end
      #1;
      pop_exp(v, d);
      eW = exp_wr_gnt();
      eR = exp_rd_gnt();
      nVec++; if ({wr_gnt, rd_gnt} !== {eW, eR}) begin nMis++; $display("FAIL rnd_gnt n=%0d: got %b%b want %b%b", n, wr_gnt, rd_gnt, eW, eR); end
      nVec++; if (bram_en !== ((eW && int'(wr_addr) < DEPTH) || (eR && int'(rd_addr) < DEPTH))) begin nMis++; $display("FAIL rnd_bram_en n=%0d: got %b", n, bram_en); end
      nVec++; if (bram_we !== (eW && int'(wr_addr) < DEPTH)) begin nMis++; $display("FAIL rnd_bram_we n=%0d: got %b", n, bram_we); end
      nVec++; if (rd_dout_vld !== v) begin nMis++; $display("FAIL rnd_vld n=%0d: got %b want %b", n, rd_dout_vld, v); end
      if (v) begin
        nVec++; if (rd_dout !== d) begin nMis++; $display("FAIL rnd_dout n=%0d: got %h want %h", n, rd_dout, d); end
      end
      nVec++; if (wr_cnt !== (AW+1)'(mWrCnt)) begin nMis++; $display("FAIL rnd_wr_cnt n=%0d: got %0d want %0d", n, wr_cnt, mWrCnt); end
      nVec++; if (addr_err !== mAddrErr) begin nMis++; $display("FAIL rnd_addr_err n=%0d: got %b want %b", n, addr_err, mAddrErr); end
      tick();
      wrPend = wr_req && !eW;
      rdPend = rd_req && !eR;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      pop_exp(v, d);
      nVec++; if (rd_dout_vld !== v) begin nMis++; $display("FAIL rnd_drain_vld j=%0d: got %b want %b", j, rd_dout_vld, v); end
      if (v) begin
        nVec++; if (rd_dout !== d) begin nMis++; $display("FAIL rnd_drain_dout j=%0d: got %h want %h", j, rd_dout, d); end
      end
      tick();
    end
  endtask

  task automatic test_write_only();
    bit           v;
    logic [W-1:0] d;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      wr_req = 1'b1; wr_addr = AW'(i); wr_din = 32'(i * 7 + 3);
      #1;
      nVec++; if ({wr_gnt, bram_we} !== 2'b11) begin nMis++; $display("FAIL wo_gnt i=%0d: got %b want 11", i, {wr_gnt, bram_we}); end
      if (i == DEPTH - 1) begin
        nVec++; if (wr_cnt !== 17'(DEPTH - 1)) begin nMis++; $display("FAIL wo_cnt_last: got %0d want %0d", wr_cnt, DEPTH - 1); end
        nVec++; if (feat_done !== 1'b0) begin nMis++; $display("FAIL wo_done_early: got %b want 0", feat_done); end
      end
      tick();
    end
    wr_req = 1'b0;
    #1;
    nVec++; if (wr_cnt !== 17'd43328) begin nMis++; $display("FAIL wo_cnt_full: got %0d want 43328", wr_cnt); end
    nVec++; if (feat_done !== 1'b0) begin nMis++; $display("FAIL wo_done_same_cycle: got %b want 0", feat_done); end
    tick();
    nVec++; if (feat_done !== 1'b1) begin nMis++; $display("FAIL wo_done_next: got %b want 1", feat_done); end
    wr_req = 1'b1; wr_addr = '0; wr_din = 32'h1234_5678;
    tick();
    wr_req = 1'b0;
    #1;
    nVec++; if (wr_cnt !== 17'd43328) begin nMis++; $display("FAIL wo_cnt_sat: got %0d want 43328", wr_cnt); end
    nVec++; if (feat_done !== 1'b1) begin nMis++; $display("FAIL wo_done_held: got %b want 1", feat_done); end
    rd_req = 1'b1; rd_addr = AW'(100);
    tick();
    rd_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      pop_exp(v, d);
      nVec++; if (rd_dout_vld !== (j == 1)) begin nMis++; $display("FAIL wo_rb_vld j=%0d: got %b want %b", j, rd_dout_vld, j == 1); end
      if (j == 1) begin
        nVec++; if (rd_dout !== 32'd703) begin nMis++; $display("FAIL wo_rb_dout: got %0d want 703", rd_dout); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    rd_req = 1'b1; rd_addr = AW'(100);
    #1;
    nVec++; if (rd_gnt !== 1'b1) begin nMis++; $display("FAIL mid_rd_gnt: got %b want 1", rd_gnt); end
    tick();
    rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    nVec++; if (wr_cnt !== '0) begin nMis++; $display("FAIL mid_wr_cnt: got %0d want 0", wr_cnt); end
    nVec++; if (feat_done !== 1'b0) begin nMis++; $display("FAIL mid_done: got %b want 0", feat_done); end
    nVec++; if (addr_err !== 1'b0) begin nMis++; $display("FAIL mid_addr_err: got %b want 0", addr_err); end
    do_reset();
    for (int j = 0; j < 4; j++) begin
      #1;
      nVec++; if ({rd_dout_vld, rd_dout} !== '0) begin nMis++; $display("FAIL mid_no_vld j=%0d: got %b/%h want 0/0", j, rd_dout_vld, rd_dout); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) sh[i] = '0;
    cyc = 0; nVec = 0; nMis = 0;
    waitWrites = 0; mWrCnt = 0; mDone = 1'b0; mAddrErr = 1'b0;
    rst_n = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_din = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_contention();
    test_readback();
    test_oob();
    test_random();
    test_write_only();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
